// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run-control slice.
package stopwatch_pkg;

  localparam int SW_DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    FULL    = 2'b11
  } sw_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to the count tick; wrap marks the last cycle of each tick period.
module tick_prescaler import stopwatch_pkg::*; #(
  parameter int unsigned TICK_DIV = 32'd100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load_zero,
  output logic wrap
);

  localparam logic [SW_DIV_W-1:0] LAST_C = SW_DIV_W'(TICK_DIV - 32'd1);

  logic [SW_DIV_W-1:0] div_cnt_r;

  // Prescaler counter: cleared on request, advances and wraps while enabled, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
    end else if (load_zero) begin
      div_cnt_r <= '0;
    end else if (en) begin
      if (div_cnt_r == LAST_C) begin
        div_cnt_r <= '0;
      end else begin
        div_cnt_r <= div_cnt_r + SW_DIV_W'(1);
      end
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

  assign wrap = en & (div_cnt_r == LAST_C);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run-control sequencer: command edge detect, IDLE/RUNNING/PAUSED/FULL FSM,
// one-cycle datapath clear and the masked 1 Hz count enable.
module stopwatch_ctrl import stopwatch_pkg::*; #(
  parameter int unsigned TICK_DIV = 32'd100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       reset,
  input  logic       at_max,
  output logic       tick_en,
  output logic       clr,
  output logic [1:0] status
);

  sw_state_t state_r;
  logic      start_prev_r;
  logic      stop_prev_r;
  logic      reset_prev_r;
  logic      clr_r;
  logic      start_ev_s;
  logic      stop_ev_s;
  logic      reset_ev_s;
  logic      run_s;
  logic      load_zero_s;
  logic      wrap_s;

  assign start_ev_s = start & ~start_prev_r;
  assign stop_ev_s  = stop  & ~stop_prev_r;
  assign reset_ev_s = reset & ~reset_prev_r;

  // Previous-value flops for rising-edge detection of the user commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev_r <= 1'b0;
      stop_prev_r  <= 1'b0;
      reset_prev_r <= 1'b0;
    end else begin
      start_prev_r <= start;
      stop_prev_r  <= stop;
      reset_prev_r <= reset;
    end
  end

  // Run FSM and clear pulse; a reset event overrides every other command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      clr_r   <= 1'b0;
    end else if (reset_ev_s) begin
      state_r <= IDLE;
      clr_r   <= 1'b1;
    end else begin
      clr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_ev_s) begin
            state_r <= RUNNING;
          end else begin
            state_r <= IDLE;
          end
        end
        RUNNING: begin
          if (stop_ev_s) begin
            state_r <= PAUSED;
          end else if (at_max) begin
            state_r <= FULL;
          end else begin
            state_r <= RUNNING;
          end
        end
        PAUSED: begin
          if (start_ev_s) begin
            state_r <= RUNNING;
          end else begin
            state_r <= PAUSED;
          end
        end
        FULL: begin
          state_r <= FULL;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Starting from IDLE begins a fresh second; resuming from PAUSED keeps the partial one
  assign run_s       = (state_r == RUNNING);
  assign load_zero_s = reset_ev_s | ((state_r == IDLE) & start_ev_s);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (run_s),
    .load_zero (load_zero_s),
    .wrap      (wrap_s)
  );

  assign tick_en = wrap_s & ~at_max;
  assign clr     = clr_r;
  assign status  = state_r;

endmodule
